// File: rtl/fwnoc_router_mon_pkg.sv
// rtl/fwnoc_router_mon_pkg.sv - channel indices and trace layout helpers for the router monitor
package fwnoc_router_mon_pkg;

  localparam int NUM_PORTS = 5;
  localparam int CH_HE = 0;
  localparam int CH_HI = 1;
  localparam int CH_NE = 2;
  localparam int CH_NI = 3;
  localparam int CH_SE = 4;
  localparam int CH_SI = 5;
  localparam int CH_EE = 6;
  localparam int CH_EI = 7;
  localparam int CH_WE = 8;
  localparam int CH_WI = 9;
  localparam int CH_W = $clog2(2 * NUM_PORTS);
  localparam int HDR_ID_W = 4;

  // Trace entry, msb first: {x_id, y_id, chan, timestamp, data}
  function automatic int trace_w(input int ch_w, input int ts_w, input int dat_w);
    return 2 * HDR_ID_W + ch_w + ts_w + dat_w;
  endfunction

  function automatic int off_ts(input int dat_w);
    return dat_w;
  endfunction

  function automatic int off_ch(input int ts_w, input int dat_w);
    return ts_w + dat_w;
  endfunction

  function automatic int off_y(input int ch_w, input int ts_w, input int dat_w);
    return ch_w + ts_w + dat_w;
  endfunction

  function automatic int off_x(input int ch_w, input int ts_w, input int dat_w);
    return HDR_ID_W + ch_w + ts_w + dat_w;
  endfunction

endpackage

// File: rtl/fwnoc_mon_fifo.sv
// rtl/fwnoc_mon_fifo.sv - synchronous trace FIFO with flush and push-on-full-when-popping
module fwnoc_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_tdata,
  input  logic             wr_tvalid,
  output logic             wr_tready,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra msb distinguishes full from empty when the index bits match
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = rd_tready & ~empty;
  assign wr_tready = ~full | do_pop;
  assign do_push   = wr_tvalid & wr_tready;
  assign rd_tvalid = ~empty;
  assign rd_tdata  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_tdata;
  end

endmodule

// File: rtl/fwnoc_router_mon.sv
// rtl/fwnoc_router_mon.sv - passive per-channel transfer/stall counters and trace capture
module fwnoc_router_mon
  import fwnoc_router_mon_pkg::*;
#(
  parameter int X_ID        = 0,
  parameter int Y_ID        = 0,
  parameter int NUM_CH      = 10,
  parameter int DAT_W       = 32,
  parameter int CNT_W       = 32,
  parameter int TS_W        = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [NUM_CH*DAT_W-1:0]                           mon_dat,
  input  logic [NUM_CH-1:0]                                 mon_valid,
  input  logic [NUM_CH-1:0]                                 mon_ready,
  input  logic                                              enable,
  input  logic                                              clear,
  input  logic [NUM_CH-1:0]                                 trace_mask,
  input  logic [$clog2(NUM_CH)-1:0]                         cnt_sel,
  output logic [CNT_W-1:0]                                  cnt_xfer,
  output logic [CNT_W-1:0]                                  cnt_stall,
  output logic [CNT_W-1:0]                                  drop_cnt,
  output logic [trace_w($clog2(NUM_CH), TS_W, DAT_W)-1:0]   trc_dat,
  output logic                                              trc_valid,
  input  logic                                              trc_ready
);

  localparam int SW = $clog2(NUM_CH);
  localparam int TW = trace_w(SW, TS_W, DAT_W);
  localparam int PW = $clog2(NUM_CH + 1);
  localparam int DW = CNT_W + PW + 1;
  localparam logic [DW-1:0] DROP_MAX = {{(DW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0]  xfer_cnt  [NUM_CH];
  logic [CNT_W-1:0]  stall_cnt [NUM_CH];
  logic [NUM_CH-1:0] xfer;
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] cap_vec;
  logic [SW-1:0]     cap_ch;
  logic [DAT_W-1:0]  cap_dat;
  logic [PW-1:0]     cap_num;
  logic              any_cap;
  logic              fifo_ready;
  logic [TS_W-1:0]   ts;
  logic [TW-1:0]     cap_entry;
  logic [DW-1:0]     drop_inc;
  logic [DW-1:0]     drop_sum;
  logic [CNT_W-1:0]  sel_x;
  logic [CNT_W-1:0]  sel_s;

  assign xfer    = mon_valid & mon_ready;
  assign stall   = mon_valid & ~mon_ready;
  assign cap_vec = xfer & trace_mask & {NUM_CH{enable}};
  assign any_cap = |cap_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clock) begin
      if (reset || clear) begin
        xfer_cnt[i]  <= '0;
        stall_cnt[i] <= '0;
      end else if (enable) begin
        if (xfer[i] && !(&xfer_cnt[i]))   xfer_cnt[i]  <= xfer_cnt[i] + 1'b1;
        if (stall[i] && !(&stall_cnt[i])) stall_cnt[i] <= stall_cnt[i] + 1'b1;
      end
    end
  end

  // Descending scan leaves the lowest capturing channel as the winner
  always_comb begin
    cap_ch  = '0;
    cap_dat = '0;
    cap_num = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cap_vec[i]) begin
        cap_ch  = SW'(i);
        cap_dat = mon_dat[i*DAT_W +: DAT_W];
      end
      cap_num = cap_num + PW'(cap_vec[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) ts <= '0;
    else                ts <= ts + 1'b1;
  end

  assign cap_entry = {4'(X_ID), 4'(Y_ID), cap_ch, ts, cap_dat};

  fwnoc_mon_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .wr_tdata  (cap_entry),
    .wr_tvalid (any_cap),
    .wr_tready (fifo_ready),
    .rd_tdata  (trc_dat),
    .rd_tvalid (trc_valid),
    .rd_tready (trc_ready)
  );

  // Losers of arbitration plus a winner refused by a full FIFO
  assign drop_inc = DW'(cap_num) - DW'(any_cap) + DW'(any_cap & ~fifo_ready);
  assign drop_sum = DW'(drop_cnt) + drop_inc;

  always_ff @(posedge clock) begin
    if (reset || clear)         drop_cnt <= '0;
    else if (drop_sum > DROP_MAX) drop_cnt <= '1;
    else                        drop_cnt <= drop_sum[CNT_W-1:0];
  end

  always_comb begin
    sel_x = '0;
    sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel == SW'(i)) begin
        sel_x = xfer_cnt[i];
        sel_s = stall_cnt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_xfer  <= '0;
      cnt_stall <= '0;
    end else begin
      cnt_xfer  <= sel_x;
      cnt_stall <= sel_s;
    end
  end

endmodule

// File: tb/tb_fwnoc_router_mon.sv
// tb/tb_fwnoc_router_mon.sv - scoreboard bench for fwnoc_router_mon
module tb_fwnoc_router_mon;
  import fwnoc_router_mon_pkg::*;

  localparam int NCH   = 10;
  localparam int DW    = 16;
  localparam int CW    = 4;
  localparam int TSW   = 16;
  localparam int DEPTH = 16;
  localparam int XI    = 3;
  localparam int YI    = 5;
  localparam int SW    = $clog2(NCH);
  localparam int TW    = trace_w(SW, TSW, DW);
  localparam int CMAX  = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*DW-1:0] mon_dat;
  logic [NCH-1:0]    mon_valid;
  logic [NCH-1:0]    mon_ready;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [NCH-1:0]    trace_mask;
  logic [SW-1:0]     cnt_sel;
  logic [CW-1:0]     cnt_xfer;
  logic [CW-1:0]     cnt_stall;
  logic [CW-1:0]     drop_cnt;
  logic [TW-1:0]     trc_dat;
  logic              trc_valid;
  logic              trc_ready = 1'b0;

  fwnoc_router_mon #(
    .X_ID        (XI),
    .Y_ID        (YI),
    .NUM_CH      (NCH),
    .DAT_W       (DW),
    .CNT_W       (CW),
    .TS_W        (TSW),
    .TRACE_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mon_dat    (mon_dat),
    .mon_valid  (mon_valid),
    .mon_ready  (mon_ready),
    .enable     (enable),
    .clear      (clear),
    .trace_mask (trace_mask),
    .cnt_sel    (cnt_sel),
    .cnt_xfer   (cnt_xfer),
    .cnt_stall  (cnt_stall),
    .drop_cnt   (drop_cnt),
    .trc_dat    (trc_dat),
    .trc_valid  (trc_valid),
    .trc_ready  (trc_ready)
  );

  always #5 clock = ~clock;

  logic [TSW-1:0] ts_m;
  always @(posedge clock) ts_m <= (reset || clear) ? '0 : ts_m + 1'b1;

  int            checks = 0;
  int            errors = 0;
  int            exp_drop = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; called just after a falling edge
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] r, input logic rdy);
    logic [NCH-1:0] cap;
    logic [TW-1:0]  e;
    int             n;
    mon_valid = v;
    mon_ready = r;
    trc_ready = rdy;
    for (int i = 0; i < NCH; i++) mon_dat[i*DW +: DW] = DW'($urandom);
    check("trc_valid", 64'(trc_valid), 64'(exp_q.size() > 0));
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    if (!(reset || clear)) begin
      if (rdy && exp_q.size() > 0) check("trc_dat", 64'(trc_dat), 64'(exp_q.pop_front()));
      cap = enable ? (v & r & trace_mask) : '0;
      n = $countones(cap);
      if (n > 0) begin
        e = '0;
        for (int i = NCH - 1; i >= 0; i--)
          if (cap[i]) e = {4'(XI), 4'(YI), SW'(i), ts_m, mon_dat[i*DW +: DW]};
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else n++;
        exp_drop = exp_drop + n - 1;
        if (exp_drop > CMAX) exp_drop = CMAX;
      end
    end
    @(negedge clock);
    if (reset || clear) begin
      exp_q.delete();
      exp_drop = 0;
    end
  endtask

  task automatic rd_cnt(input int sel, input int ex, input int es);
    cnt_sel = SW'(sel);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    check($sformatf("xfer_ch%0d", sel), 64'(cnt_xfer), 64'(ex));
    check($sformatf("stall_ch%0d", sel), 64'(cnt_stall), 64'(es));
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      cycle('0, '0, 1'b1);
      guard++;
    end
    cycle('0, '0, 1'b0);
  endtask

  initial begin
    mon_dat    = '0;
    mon_valid  = '0;
    mon_ready  = '0;
    trace_mask = '0;
    cnt_sel    = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_xfer", 64'(cnt_xfer), 64'd0);
    check("rst_stall", 64'(cnt_stall), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_valid", 64'(trc_valid), 64'd0);

    enable = 1'b1;
    repeat (5) cycle(10'h008, 10'h008, 1'b0);
    rd_cnt(3, 5, 0);

    repeat (4) cycle(10'h001, 10'h000, 1'b0);
    cycle(10'h001, 10'h001, 1'b0);
    rd_cnt(0, 1, 4);

    // ch1, ch4, ch7 in one cycle: ch1 wins, two losers dropped
    trace_mask = '1;
    cycle(10'h092, 10'h092, 1'b0);
    check("win_chan", 64'(trc_dat[off_ch(TSW, DW) +: SW]), 64'd1);
    check("win_hdr", 64'(trc_dat[off_y(SW, TSW, DW) +: 8]), 64'({4'(XI), 4'(YI)}));
    check("drop_arb", 64'(drop_cnt), 64'd2);
    drain();

    trace_mask = 10'h004;
    repeat (17) cycle(10'h004, 10'h004, 1'b0);
    check("drop_full", 64'(drop_cnt), 64'd3);
    check("hold0", 64'(trc_dat), 64'(exp_q[0]));
    cycle('0, '0, 1'b0);
    check("hold1", 64'(trc_dat), 64'(exp_q[0]));
    cycle(10'h004, 10'h004, 1'b1);
    check("drop_pushpop", 64'(drop_cnt), 64'd3);
    drain();

    trace_mask = '0;
    repeat (20) cycle(10'h020, 10'h020, 1'b0);
    rd_cnt(5, CMAX, 0);
    repeat (20) cycle(10'h020, 10'h000, 1'b0);
    rd_cnt(5, CMAX, CMAX);

    enable = 1'b0;
    trace_mask = '1;
    repeat (3) cycle(10'h040, 10'h040, 1'b0);
    enable = 1'b1;
    rd_cnt(6, 0, 0);
    rd_cnt(12, 0, 0);

    trace_mask = 10'h004;
    repeat (3) cycle(10'h004, 10'h004, 1'b0);
    clear = 1'b1;
    cycle(10'h024, 10'h024, 1'b1);
    clear = 1'b0;
    check("clr_valid", 64'(trc_valid), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    rd_cnt(5, 0, 0);
    rd_cnt(3, 0, 0);
    cycle(10'h004, 10'h004, 1'b0);
    drain();

    cnt_sel = SW'(3);
    repeat (3) cycle(10'h00C, 10'h00C, 1'b0);
    reset = 1'b1;
    cycle(10'h004, 10'h004, 1'b1);
    reset = 1'b0;
    check("rst2_valid", 64'(trc_valid), 64'd0);
    check("rst2_xfer", 64'(cnt_xfer), 64'd0);
    rd_cnt(3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
